// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file and its clear sequencer.
package reg_file_pkg;

    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_NREG = 4;

    typedef enum logic {
        IDLE,
        SWEEP
    } clr_state_t;

    // Register index at the default geometry
    typedef logic [$clog2(DEF_NREG)-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_n_if.sv
// Datapath-facing port bundle of reg_file_n: write/increment/clear controls and read results.
interface reg_file_n_if #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 4
);
    localparam int unsigned AW = $clog2(NREG);

    logic          we;
    logic [AW-1:0] dr;
    logic [DW-1:0] i;
    logic [AW-1:0] sr;
    logic [DW-1:0] s;
    logic [DW-1:0] d;
    logic          inc;
    logic [AW-1:0] ir;
    logic          ovf;
    logic          clr_req;
    logic          busy;

    modport master (
        output we, dr, i, sr, inc, ir, clr_req,
        input  s, d, ovf, busy
    );

    modport slave (
        input  we, dr, i, sr, inc, ir, clr_req,
        output s, d, ovf, busy
    );
endinterface

// File: rtl/reg_file_clr_seq.sv
// Clear sweep sequencer: on clr_req, zeroes registers 0..NREG-1, one per cycle, with busy raised.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int unsigned NREG = DEF_NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    busy,
    output logic                    clr_stb,
    output logic [$clog2(NREG)-1:0] clr_idx
);
    localparam int unsigned AW = $clog2(NREG);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= (state_nxt == SWEEP);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == AW'(NREG - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign clr_stb = (state == SWEEP);
    assign clr_idx = cnt;

endmodule

// File: rtl/reg_file_n.sv
// NREG x DW register file: one write port, S/D read ports, increment port with overflow, clear sweep.
// Optional read-during-write forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_n
    import reg_file_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned NREG = DEF_NREG
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_n_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [DW-1:0] r [NREG];
    logic          busy;
    logic          clr_stb;
    logic [AW-1:0] clr_idx;
    logic          wr_ok;
    logic          inc_ok;
    logic          ovf_q;

    reg_file_clr_seq #(
        .NREG (NREG)
    ) u_clr_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (bus.clr_req),
        .busy    (busy),
        .clr_stb (clr_stb),
        .clr_idx (clr_idx)
    );

    // A same-address write beats the increment; both are locked out while sweeping.
    assign wr_ok  = bus.we && !busy;
    assign inc_ok = bus.inc && !busy && !(bus.we && (bus.dr == bus.ir));

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NREG; k++) begin
            if (rst) begin
                r[k] <= '0;
            end else if (clr_stb && (clr_idx == AW'(k))) begin
                r[k] <= '0;
            end else if (wr_ok && (bus.dr == AW'(k))) begin
                r[k] <= bus.i;
            end else if (inc_ok && (bus.ir == AW'(k))) begin
                r[k] <= r[k] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= inc_ok && (&r[bus.ir]);
        end
    end

    always_comb begin
        bus.s = r[bus.sr];
        bus.d = r[bus.dr];
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && !rst) begin
            bus.d = bus.i;
            if (bus.sr == bus.dr) begin
                bus.s = bus.i;
            end
        end
`endif
    end

    assign bus.ovf  = ovf_q;
    assign bus.busy = busy;

endmodule

// File: tb/tb_reg_file_n.sv
// Directed self-checking bench for reg_file_n: default 4x8 instance plus an 8x16 instance.
module tb_reg_file_n;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    reg_file_n_if #(.DW(8),  .NREG(4)) bus  ();
    reg_file_n_if #(.DW(16), .NREG(8)) bus2 ();

    reg_file_n #(.DW(8),  .NREG(4)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    reg_file_n #(.DW(16), .NREG(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.sr = 2'd1;
        bus.dr = 2'd2;
        #1;
        tests++;
        if (bus.s !== 8'h00) begin fails++; $display("FAIL reset_s got %h want 00", bus.s); end
        tests++;
        if (bus.d !== 8'h00) begin fails++; $display("FAIL reset_d got %h want 00", bus.d); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++;
        if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    endtask

    task automatic test_write();
        bus.we = 1'b1; bus.dr = 2'd2; bus.i = 8'hA5; bus.sr = 2'd2;
        #1;
        tests++;
`ifdef REG_FILE_BYPASS_EN
        if (bus.s !== 8'hA5) begin fails++; $display("FAIL write_bypass_s got %h want a5", bus.s); end
`else
        if (bus.s !== 8'h00) begin fails++; $display("FAIL write_same_cycle_s got %h want 00", bus.s); end
`endif
        tick();
        bus.we = 1'b0;
        #1;
        tests++;
        if (bus.s !== 8'hA5) begin fails++; $display("FAIL write_s got %h want a5", bus.s); end
        tests++;
        if (bus.d !== 8'hA5) begin fails++; $display("FAIL write_d got %h want a5", bus.d); end
    endtask

    task automatic test_inc_wrap();
        bus.we = 1'b1; bus.dr = 2'd1; bus.i = 8'hFF;
        tick();
        bus.we = 1'b0; bus.inc = 1'b1; bus.ir = 2'd1; bus.sr = 2'd1;
        tick();
        bus.inc = 1'b0;
        #1;
        tests++;
        if (bus.s !== 8'h00) begin fails++; $display("FAIL inc_wrap_val got %h want 00", bus.s); end
        tests++;
        if (bus.ovf !== 1'b1) begin fails++; $display("FAIL inc_wrap_ovf got %b want 1", bus.ovf); end
        tick();
        tests++;
        if (bus.ovf !== 1'b0) begin fails++; $display("FAIL inc_ovf_pulse got %b want 0", bus.ovf); end
        bus.inc = 1'b1;
        tick();
        bus.inc = 1'b0;
        #1;
        tests++;
        if (bus.s !== 8'h01) begin fails++; $display("FAIL inc_second_val got %h want 01", bus.s); end
        tests++;
        if (bus.ovf !== 1'b0) begin fails++; $display("FAIL inc_second_ovf got %b want 0", bus.ovf); end
    endtask

    task automatic test_collision();
        bus.we = 1'b1; bus.dr = 2'd3; bus.i = 8'h10;
        bus.inc = 1'b1; bus.ir = 2'd3;
        tick();
        bus.we = 1'b0; bus.inc = 1'b0; bus.sr = 2'd3;
        #1;
        tests++;
        if (bus.s !== 8'h10) begin fails++; $display("FAIL collide_same_val got %h want 10", bus.s); end
        tests++;
        if (bus.ovf !== 1'b0) begin fails++; $display("FAIL collide_same_ovf got %b want 0", bus.ovf); end
        bus.we = 1'b1; bus.dr = 2'd0; bus.i = 8'h07;
        tick();
        bus.dr = 2'd3; bus.i = 8'h22;
        bus.inc = 1'b1; bus.ir = 2'd0;
        tick();
        bus.we = 1'b0; bus.inc = 1'b0; bus.sr = 2'd0;
        #1;
        tests++;
        if (bus.s !== 8'h08) begin fails++; $display("FAIL collide_diff_inc got %h want 08", bus.s); end
        tests++;
        if (bus.d !== 8'h22) begin fails++; $display("FAIL collide_diff_wr got %h want 22", bus.d); end
        tests++;
        if (bus.ovf !== 1'b0) begin fails++; $display("FAIL collide_diff_ovf got %b want 0", bus.ovf); end
    endtask

    task automatic test_clear();
        logic [7:0] pre [4];
        logic [7:0] exp [4];
        int         nbusy;
        pre = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp = '{8'h00, 8'h00, 8'h66, 8'h00};
        for (int k = 0; k < 4; k++) begin
            bus.we = 1'b1; bus.dr = reg_idx_t'(k); bus.i = pre[k];
            tick();
        end
        bus.we = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL clear_busy_start got %b want 1", bus.busy); end
        nbusy = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.busy === 1'b1) nbusy++;
            bus.we = 1'b0;
            // cycle N+2: write to cleared R0; N+4: last busy cycle; N+5: first accepted
            if (c == 1) begin bus.we = 1'b1; bus.dr = 2'd0; bus.i = 8'h55; end
            if (c == 3) begin bus.we = 1'b1; bus.dr = 2'd1; bus.i = 8'h77; end
            if (c == 4) begin bus.we = 1'b1; bus.dr = 2'd2; bus.i = 8'h66; end
            tick();
        end
        bus.we = 1'b0;
        tests++;
        if (nbusy != 4) begin fails++; $display("FAIL clear_busy_len got %0d want 4", nbusy); end
        for (int k = 0; k < 4; k++) begin
            bus.sr = reg_idx_t'(k);
            #1;
            tests++;
            if (bus.s !== exp[k]) begin fails++; $display("FAIL clear_reg%0d got %h want %h", k, bus.s, exp[k]); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bus.we = 1'b1; bus.dr = 2'd1; bus.i = 8'h09;
        tick();
        bus.dr = 2'd3;
        tick();
        bus.we = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tick();
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL midsweep_busy got %b want 1", bus.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL midsweep_rst_busy got %b want 0", bus.busy); end
        for (int k = 0; k < 4; k++) begin
            bus.sr = reg_idx_t'(k);
            #1;
            tests++;
            if (bus.s !== 8'h00) begin fails++; $display("FAIL midsweep_reg%0d got %h want 00", k, bus.s); end
        end
        bus.we = 1'b1; bus.dr = 2'd3; bus.i = 8'h3C;
        tick();
        bus.we = 1'b0; bus.sr = 2'd3;
        #1;
        tests++;
        if (bus.s !== 8'h3C) begin fails++; $display("FAIL midsweep_write got %h want 3c", bus.s); end
    endtask

    task automatic test_back_to_back();
        int guard;
        bus.clr_req = 1'b1;
        tick();
        for (int c = 0; c < 12; c++) begin
            tests++;
            if (bus.busy !== ((c % 5) != 4)) begin
                fails++;
                $display("FAIL b2b_busy_c%0d got %b want %b", c, bus.busy, ((c % 5) != 4));
            end
            tick();
        end
        bus.clr_req = 1'b0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", bus.busy); end
    endtask

    task automatic test_param();
        int nbusy;
        bus2.we = 1'b1; bus2.dr = 3'd5; bus2.i = 16'hFFFF;
        tick();
        bus2.we = 1'b0; bus2.inc = 1'b1; bus2.ir = 3'd5; bus2.sr = 3'd5;
        tick();
        bus2.inc = 1'b0;
        #1;
        tests++;
        if (bus2.s !== 16'h0000) begin fails++; $display("FAIL p16_wrap_val got %h want 0000", bus2.s); end
        tests++;
        if (bus2.ovf !== 1'b1) begin fails++; $display("FAIL p16_wrap_ovf got %b want 1", bus2.ovf); end
        bus2.we = 1'b1; bus2.dr = 3'd7; bus2.i = 16'h1234;
        tick();
        bus2.we = 1'b0;
        bus2.clr_req = 1'b1;
        tick();
        bus2.clr_req = 1'b0;
        nbusy = 0;
        for (int c = 0; c < 14; c++) begin
            if (bus2.busy === 1'b1) nbusy++;
            tick();
        end
        tests++;
        if (nbusy != 8) begin fails++; $display("FAIL p16_sweep_len got %0d want 8", nbusy); end
        bus2.sr = 3'd7;
        #1;
        tests++;
        if (bus2.s !== 16'h0000) begin fails++; $display("FAIL p16_sweep_r7 got %h want 0000", bus2.s); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        tests = 0;
        fails = 0;
        bus.we = 1'b0;  bus.dr = '0;  bus.i = '0;  bus.sr = '0;
        bus.inc = 1'b0; bus.ir = '0;  bus.clr_req = 1'b0;
        bus2.we = 1'b0; bus2.dr = '0; bus2.i = '0; bus2.sr = '0;
        bus2.inc = 1'b0; bus2.ir = '0; bus2.clr_req = 1'b0;
        tick();
        test_reset();
        test_write();
        test_inc_wrap();
        test_collision();
        test_clear();
        test_reset_mid_sweep();
        test_back_to_back();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
